mem_wb_stage: RTL and testbench

// - MEM->WB pipeline register plus write-back select. Last pipeline stage.
// - Captures the MEM result and aligns / sign-extends load data from the data SRAM.
// - Holds the stage until a late load response arrives.
// - Drives regWriteEn_wb / rd_no_wb / regWriteData to the regfile and to the operand-forwarding unit.

---
 rtl/mem_wb_stage_pkg.sv | 31 +++
 rtl/mem_wb_stage_load_align.sv | 30 +++
 rtl/mem_wb_stage.sv | 133 +++++++++++++
 tb/tb_mem_wb_stage.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared types for the MEM->WB stage: data/register widths, write-back
// source and load type encodings, and the WB stage state encoding.
package mem_wb_stage_pkg;

    typedef logic [31:0] DType;
    typedef logic [4:0]  Gr;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } WbSrc;

    typedef enum logic [2:0] {
        LD_B  = 3'd0,
        LD_H  = 3'd1,
        LD_W  = 3'd2,
        LD_BU = 3'd3,
        LD_HU = 3'd4
    } LdType;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_RUN   = 2'd1,
        WB_WAIT  = 2'd2,
        WB_DRAIN = 2'd3
    } wb_state_t;

    localparam DType PC_STEP = 32'd4;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load data alignment: picks the byte/half addressed by addr out of the raw
// SRAM word and sign- or zero-extends it. Misaligned half/word accesses are
// trapped upstream, so addr[0] is ignored for halves and addr for words.
module mem_wb_stage_load_align
    import mem_wb_stage_pkg::*;
(
    input  DType       rdata,
    input  logic [1:0] addr,
    input  LdType      load_type,
    output DType       load_data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Select the addressed lane, then extend according to the load type.
    always_comb begin
        byte_val  = rdata[{addr, 3'b000} +: 8];
        half_val  = addr[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        unique case (load_type)
            LD_B:    load_data = {{24{byte_val[7]}}, byte_val};
            LD_BU:   load_data = {24'h0, byte_val};
            LD_H:    load_data = {{16{half_val[15]}}, half_val};
            LD_HU:   load_data = {16'h0, half_val};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register and write-back select. Holds a load until its
// SRAM response arrives (or uses a response that arrived in the load cycle),
// and absorbs the response still owed by a flushed load before accepting
// new work.
//
// state    | meaning
// WB_IDLE  | no valid instruction
// WB_RUN   | valid; non-load, or load whose data is buffered
// WB_WAIT  | valid load, response pending
// WB_DRAIN | load killed by flush, response still owed
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter logic LOAD_BUF_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        mem_valid,
    output logic        wb_allowin,
    input  logic        regWriteEn_mem,
    input  Gr           rd_no_mem,
    input  DType        aluout,
    input  WbSrc        wbSrc_mem,
    input  LdType       loadType_mem,
    input  DType        pc_mem,
    input  logic        data_rdata_valid,
    input  DType        data_rdata,
    output logic        regWriteEn_wb,
    output Gr           rd_no_wb,
    output DType        regWriteData,
    output DType        debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we
);

    wb_state_t state;
    DType      aluout_r;
    DType      pc_r;
    DType      buf_data;
    Gr         rd_no_r;
    logic      reg_we_r;
    WbSrc      wbsrc_r;
    LdType     ldtype_r;
    logic      buf_valid;

    logic      wb_valid;
    logic      load_ready;
    logic      wb_ready_go;
    logic      load_en;
    logic      early_rsp;
    DType      load_word;
    DType      load_data;

    // Handshake: a load is ready once its data is buffered or arrives while
    // waiting. DRAIN blocks new work until the owed response is absorbed.
    always_comb begin
        wb_valid    = (state == WB_RUN) || (state == WB_WAIT);
        load_ready  = buf_valid || ((state == WB_WAIT) && data_rdata_valid);
        wb_ready_go = (wbsrc_r != WB_MEM) || load_ready;
        wb_allowin  = (state != WB_DRAIN) && (!wb_valid || wb_ready_go);
        load_en     = mem_valid && wb_allowin && !flush;
        // A response during WAIT belongs to the waiting load, never to the
        // instruction entering behind it.
        early_rsp   = LOAD_BUF_EN && load_en && (wbSrc_mem == WB_MEM) &&
                      data_rdata_valid && (state != WB_WAIT);
        load_word   = buf_valid ? buf_data : data_rdata;
    end

    mem_wb_stage_load_align u_load_align (
        .rdata     (load_word),
        .addr      (aluout_r[1:0]),
        .load_type (ldtype_r),
        .load_data (load_data)
    );

    // Write-back source select and regfile strobe.
    always_comb begin
        unique case (wbsrc_r)
            WB_MEM:  regWriteData = load_data;
            WB_PC4:  regWriteData = pc_r + PC_STEP;
            default: regWriteData = aluout_r;
        endcase
        regWriteEn_wb  = wb_valid && wb_ready_go && reg_we_r &&
                         (rd_no_r != '0) && !flush;
        rd_no_wb       = rd_no_r;
        debug_wb_pc    = pc_r;
        debug_wb_rf_we = {4{regWriteEn_wb}};
    end

    // Stage FSM and pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WB_IDLE;
            aluout_r  <= '0;
            pc_r      <= '0;
            buf_data  <= '0;
            rd_no_r   <= '0;
            reg_we_r  <= 1'b0;
            wbsrc_r   <= WB_ALU;
            ldtype_r  <= LD_B;
            buf_valid <= 1'b0;
        end else if (flush) begin
            buf_valid <= 1'b0;
            if ((state == WB_WAIT || state == WB_DRAIN) && !data_rdata_valid) begin
                state <= WB_DRAIN;
            end else begin
                state <= WB_IDLE;
            end
        end else if (load_en) begin
            aluout_r  <= aluout;
            pc_r      <= pc_mem;
            rd_no_r   <= rd_no_mem;
            reg_we_r  <= regWriteEn_mem;
            wbsrc_r   <= wbSrc_mem;
            ldtype_r  <= loadType_mem;
            buf_valid <= early_rsp;
            buf_data  <= data_rdata;
            if (wbSrc_mem != WB_MEM || early_rsp) begin
                state <= WB_RUN;
            end else begin
                state <= WB_WAIT;
            end
        end else if (state == WB_DRAIN) begin
            if (data_rdata_valid) begin
                state <= WB_IDLE;
            end
        end else if (wb_valid && wb_ready_go) begin
            buf_valid <= 1'b0;
            state     <= WB_IDLE;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus a randomized
// run checked against a plain-arithmetic model of write-back results.
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        mem_valid;
    logic        wb_allowin;
    logic        regWriteEn_mem;
    Gr           rd_no_mem;
    DType        aluout;
    WbSrc        wbSrc_mem;
    LdType       loadType_mem;
    DType        pc_mem;
    logic        data_rdata_valid;
    DType        data_rdata;
    logic        regWriteEn_wb;
    Gr           rd_no_wb;
    DType        regWriteData;
    DType        debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;

    int n_checks = 0;
    int n_fail   = 0;

    mem_wb_stage #(.LOAD_BUF_EN(1'b1)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .mem_valid        (mem_valid),
        .wb_allowin       (wb_allowin),
        .regWriteEn_mem   (regWriteEn_mem),
        .rd_no_mem        (rd_no_mem),
        .aluout           (aluout),
        .wbSrc_mem        (wbSrc_mem),
        .loadType_mem     (loadType_mem),
        .pc_mem           (pc_mem),
        .data_rdata_valid (data_rdata_valid),
        .data_rdata       (data_rdata),
        .regWriteEn_wb    (regWriteEn_wb),
        .rd_no_wb         (rd_no_wb),
        .regWriteData     (regWriteData),
        .debug_wb_pc      (debug_wb_pc),
        .debug_wb_rf_we   (debug_wb_rf_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    // Reference load result from plain shift/mask/subtract arithmetic.
    function automatic logic [31:0] ref_load(input LdType lt, input logic [31:0] w,
                                             input int a);
        logic [31:0] v;
        case (lt)
            LD_B:  begin v = (w >> (8 * a)) & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
            LD_BU: v = (w >> (8 * a)) & 32'hFF;
            LD_H:  begin v = (w >> (8 * a)) & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
            LD_HU: v = (w >> (8 * a)) & 32'hFFFF;
            default: v = w;
        endcase
        return v;
    endfunction

    task automatic present(input logic we, input Gr rd, input DType alu, input WbSrc src,
                           input LdType lt, input DType pc);
        mem_valid      = 1'b1;
        regWriteEn_mem = we;
        rd_no_mem      = rd;
        aluout         = alu;
        wbSrc_mem      = src;
        loadType_mem   = lt;
        pc_mem         = pc;
    endtask

    task automatic idle_inputs();
        mem_valid        = 1'b0;
        regWriteEn_mem   = 1'b0;
        data_rdata_valid = 1'b0;
        flush            = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        rd_no_mem = '0; aluout = '0; wbSrc_mem = WB_ALU; loadType_mem = LD_W;
        pc_mem = '0; data_rdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (wb_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_allowin: got %b expected 1", wb_allowin); end
        n_checks++; if (regWriteEn_wb !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", regWriteEn_wb); end
        n_checks++; if (rd_no_wb !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d expected 0", rd_no_wb); end
        n_checks++; if (regWriteData !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", regWriteData); end
        n_checks++; if (debug_wb_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", debug_wb_pc); end
        n_checks++; if (debug_wb_rf_we !== 4'h0) begin n_fail++; $display("FAIL reset_rf_we: got %h expected 0", debug_wb_rf_we); end
        @(negedge clk);
    endtask

    task automatic test_alu();
        present(1'b1, 5'd5, 32'h1234_5678, WB_ALU, LD_W, 32'h1C00_0010);
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (regWriteEn_wb !== 1'b1) begin n_fail++; $display("FAIL alu_we: got %b expected 1", regWriteEn_wb); end
        n_checks++; if (rd_no_wb !== 5'd5) begin n_fail++; $display("FAIL alu_rd: got %0d expected 5", rd_no_wb); end
        n_checks++; if (regWriteData !== 32'h1234_5678) begin n_fail++; $display("FAIL alu_data: got %h expected 12345678", regWriteData); end
        n_checks++; if (debug_wb_rf_we !== 4'hF) begin n_fail++; $display("FAIL alu_rf_we: got %h expected f", debug_wb_rf_we); end
        n_checks++; if (debug_wb_pc !== 32'h1C00_0010) begin n_fail++; $display("FAIL alu_pc: got %h expected 1c000010", debug_wb_pc); end
        @(negedge clk);
        #1;
        n_checks++; if (regWriteEn_wb !== 1'b0) begin n_fail++; $display("FAIL alu_retired_we: got %b expected 0", regWriteEn_wb); end
        @(negedge clk);
    endtask

    task automatic test_load_align();
        LdType lts [3] = '{LD_B, LD_BU, LD_HU};
        DType  adr [3] = '{32'h0000_1003, 32'h0000_1003, 32'h0000_2002};
        DType  raw [3] = '{32'h8000_0000, 32'h8000_0000, 32'hBEEF_0000};
        DType  exp [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_BEEF};
        for (int i = 0; i < 3; i++) begin
            present(1'b1, 5'd10, adr[i], WB_MEM, lts[i], 32'h100);
            data_rdata_valid = 1'b1;
            data_rdata       = raw[i];
            @(negedge clk);
            idle_inputs();
            data_rdata = 32'h0;
            #1;
            n_checks++; if (regWriteEn_wb !== 1'b1) begin n_fail++; $display("FAIL align_we[%0d]: got %b expected 1", i, regWriteEn_wb); end
            n_checks++; if (regWriteData !== exp[i]) begin n_fail++; $display("FAIL align_data[%0d]: got %h expected %h", i, regWriteData, exp[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_late_load();
        present(1'b1, 5'd7, 32'h0000_0100, WB_MEM, LD_W, 32'h200);
        @(negedge clk);
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (wb_allowin !== 1'b0) begin n_fail++; $display("FAIL late_allowin[%0d]: got %b expected 0", k, wb_allowin); end
            n_checks++; if (regWriteEn_wb !== 1'b0) begin n_fail++; $display("FAIL late_we[%0d]: got %b expected 0", k, regWriteEn_wb); end
            @(negedge clk);
        end
        data_rdata_valid = 1'b1;
        data_rdata       = 32'hCAFE_F00D;
        present(1'b1, 5'd8, 32'h0000_0055, WB_ALU, LD_W, 32'h204);
        #1;
        n_checks++; if (regWriteEn_wb !== 1'b1) begin n_fail++; $display("FAIL late_rsp_we: got %b expected 1", regWriteEn_wb); end
        n_checks++; if (rd_no_wb !== 5'd7) begin n_fail++; $display("FAIL late_rsp_rd: got %0d expected 7", rd_no_wb); end
        n_checks++; if (regWriteData !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL late_rsp_data: got %h expected cafef00d", regWriteData); end
        n_checks++; if (wb_allowin !== 1'b1) begin n_fail++; $display("FAIL late_rsp_allowin: got %b expected 1", wb_allowin); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (regWriteEn_wb !== 1'b1) begin n_fail++; $display("FAIL late_next_we: got %b expected 1", regWriteEn_wb); end
        n_checks++; if (rd_no_wb !== 5'd8) begin n_fail++; $display("FAIL late_next_rd: got %0d expected 8", rd_no_wb); end
        n_checks++; if (regWriteData !== 32'h55) begin n_fail++; $display("FAIL late_next_data: got %h expected 55", regWriteData); end
        @(negedge clk);
    endtask

    task automatic test_flush();
        // Flush while waiting on a load: response is drained, never written.
        present(1'b1, 5'd9, 32'h0000_0300, WB_MEM, LD_W, 32'h300);
        @(negedge clk);
        idle_inputs();
        flush = 1'b1;
        present(1'b1, 5'd11, 32'h0000_0077, WB_ALU, LD_W, 32'h304);
        #1;
        n_checks++; if (regWriteEn_wb !== 1'b0) begin n_fail++; $display("FAIL flush_wait_we: got %b expected 0", regWriteEn_wb); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (wb_allowin !== 1'b0) begin n_fail++; $display("FAIL drain_allowin: got %b expected 0", wb_allowin); end
        n_checks++; if (regWriteEn_wb !== 1'b0) begin n_fail++; $display("FAIL drain_we: got %b expected 0", regWriteEn_wb); end
        @(negedge clk);
        data_rdata_valid = 1'b1;
        data_rdata       = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (wb_allowin !== 1'b0) begin n_fail++; $display("FAIL drain_rsp_allowin: got %b expected 0", wb_allowin); end
        n_checks++; if (regWriteEn_wb !== 1'b0) begin n_fail++; $display("FAIL drain_rsp_we: got %b expected 0", regWriteEn_wb); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (wb_allowin !== 1'b1) begin n_fail++; $display("FAIL post_drain_allowin: got %b expected 1", wb_allowin); end
        n_checks++; if (regWriteEn_wb !== 1'b0) begin n_fail++; $display("FAIL post_drain_we: got %b expected 0", regWriteEn_wb); end
        // Flush of a ready ALU op: write suppressed, incoming instruction dropped.
        present(1'b1, 5'd3, 32'h0000_0033, WB_ALU, LD_W, 32'h400);
        @(negedge clk);
        flush = 1'b1;
        present(1'b1, 5'd4, 32'h0000_0044, WB_ALU, LD_W, 32'h404);
        #1;
        n_checks++; if (regWriteEn_wb !== 1'b0) begin n_fail++; $display("FAIL flush_run_we: got %b expected 0", regWriteEn_wb); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (regWriteEn_wb !== 1'b0) begin n_fail++; $display("FAIL flush_dropped_we: got %b expected 0", regWriteEn_wb); end
        n_checks++; if (wb_allowin !== 1'b1) begin n_fail++; $display("FAIL flush_dropped_allowin: got %b expected 1", wb_allowin); end
        @(negedge clk);
    endtask

    task automatic test_rd0_jirl();
        present(1'b1, 5'd0, 32'h0000_1111, WB_ALU, LD_W, 32'h1C00_0500);
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (regWriteEn_wb !== 1'b0) begin n_fail++; $display("FAIL rd0_we: got %b expected 0", regWriteEn_wb); end
        n_checks++; if (debug_wb_pc !== 32'h1C00_0500) begin n_fail++; $display("FAIL rd0_pc: got %h expected 1c000500", debug_wb_pc); end
        @(negedge clk);
        present(1'b1, 5'd1, 32'h0000_2222, WB_PC4, LD_W, 32'hFFFF_FFFC);
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (regWriteEn_wb !== 1'b1) begin n_fail++; $display("FAIL jirl_we: got %b expected 1", regWriteEn_wb); end
        n_checks++; if (regWriteData !== 32'h0) begin n_fail++; $display("FAIL jirl_data: got %h expected 0", regWriteData); end
        @(negedge clk);
    endtask

    task automatic test_reset_wait();
        present(1'b1, 5'd12, 32'h0000_0600, WB_MEM, LD_W, 32'h600);
        @(negedge clk);
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (wb_allowin !== 1'b1) begin n_fail++; $display("FAIL rstwait_allowin: got %b expected 1", wb_allowin); end
        n_checks++; if (rd_no_wb !== 5'd0) begin n_fail++; $display("FAIL rstwait_rd: got %0d expected 0", rd_no_wb); end
        n_checks++; if (debug_wb_pc !== 32'h0) begin n_fail++; $display("FAIL rstwait_pc: got %h expected 0", debug_wb_pc); end
        n_checks++; if (regWriteData !== 32'h0) begin n_fail++; $display("FAIL rstwait_data: got %h expected 0", regWriteData); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        data_rdata_valid = 1'b1;
        data_rdata       = 32'h1357_9BDF;
        #1;
        n_checks++; if (regWriteEn_wb !== 1'b0) begin n_fail++; $display("FAIL stale_rsp_we: got %b expected 0", regWriteEn_wb); end
        n_checks++; if (wb_allowin !== 1'b1) begin n_fail++; $display("FAIL stale_rsp_allowin: got %b expected 1", wb_allowin); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (regWriteEn_wb !== 1'b0) begin n_fail++; $display("FAIL stale_after_we: got %b expected 0", regWriteEn_wb); end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            int    gap   = $urandom_range(0, 2);
            WbSrc  src   = WbSrc'($urandom_range(0, 2));
            LdType lt    = LdType'($urandom_range(0, 4));
            logic  we    = logic'($urandom_range(0, 1));
            Gr     rd    = Gr'($urandom_range(0, 31));
            DType  pc    = $urandom;
            DType  alu   = $urandom;
            DType  raw   = $urandom;
            int    dly   = 0;
            DType  exp_d;
            logic  exp_we;
            repeat (gap) @(negedge clk);
            if (src == WB_MEM) begin
                if (lt == LD_W) alu[1:0] = 2'b00;
                if (lt == LD_H || lt == LD_HU) alu[0] = 1'b0;
                dly = $urandom_range(0, 3);
            end
            case (src)
                WB_MEM:  exp_d = ref_load(lt, raw, int'(alu % 4));
                WB_PC4:  exp_d = pc + 32'd4;
                default: exp_d = alu;
            endcase
            exp_we = we && (rd != 0);
            present(we, rd, alu, src, lt, pc);
            if (src == WB_MEM && dly == 0) begin
                data_rdata_valid = 1'b1;
                data_rdata       = raw;
            end
            #1;
            n_checks++; if (wb_allowin !== 1'b1) begin n_fail++; $display("FAIL rnd_allowin[%0d]: got %b expected 1", i, wb_allowin); end
            @(negedge clk);
            idle_inputs();
            data_rdata = $urandom;
            if (dly > 0) begin
                for (int k = 1; k < dly; k++) begin
                    #1;
                    n_checks++; if (regWriteEn_wb !== 1'b0) begin n_fail++; $display("FAIL rnd_wait_we[%0d]: got %b expected 0", i, regWriteEn_wb); end
                    n_checks++; if (wb_allowin !== 1'b0) begin n_fail++; $display("FAIL rnd_wait_allowin[%0d]: got %b expected 0", i, wb_allowin); end
                    @(negedge clk);
                end
                data_rdata_valid = 1'b1;
                data_rdata       = raw;
            end
            #1;
            n_checks++; if (regWriteEn_wb !== exp_we) begin n_fail++; $display("FAIL rnd_we[%0d]: got %b expected %b", i, regWriteEn_wb, exp_we); end
            n_checks++; if (regWriteData !== exp_d) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h expected %h (src %0d lt %0d)", i, regWriteData, exp_d, src, lt); end
            n_checks++; if (rd_no_wb !== rd) begin n_fail++; $display("FAIL rnd_rd[%0d]: got %0d expected %0d", i, rd_no_wb, rd); end
            n_checks++; if (debug_wb_pc !== pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h expected %h", i, debug_wb_pc, pc); end
            @(negedge clk);
            idle_inputs();
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_align();
        test_late_load();
        test_flush();
        test_rd0_jirl();
        test_reset_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
